lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 209 ++++++++++++++++++++
 tb/tb_lsu.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit between the pipeline and a single-ported data memory.
// Memory is word-wide and big-endian; sub-word stores are done as a
// read-modify-write (RD then WR). Every memory access uses the full-word op.
//
// Optional build macro LSU_ALIGN_CHECK_EN: when defined, misaligned halfword
// and word accesses complete as errors without touching memory. When it is
// undefined, the offending low address bits are ignored.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both 1; req_ready is high only while idle. The completion is
// a single-cycle resp_valid pulse. resp_rdata/resp_err are 0 unless
// resp_valid is 1.
//
// Op encodings (DM_OP_*) are declared locally so this file is self-contained.
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dm_w,
    output logic        dm_r,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [2:0]  dm_op,
    input  logic [31:0] dm_rdata,
    output logic [1:0]  o_dbg_state
);

    localparam logic [2:0] DM_OP_WD = 3'd0;
    localparam logic [2:0] DM_OP_BS = 3'd1;
    localparam logic [2:0] DM_OP_BZ = 3'd2;
    localparam logic [2:0] DM_OP_HS = 3'd3;
    localparam logic [2:0] DM_OP_HZ = 3'd4;
    localparam logic [2:0] DM_OP_SB = 3'd5;
    localparam logic [2:0] DM_OP_SH = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_we;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_op_illegal;
    logic        w_misalign;
    logic        w_req_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;
    logic [31:0] w_aligned_addr;

    assign w_accept       = req_valid && (r_state == S_IDLE);
    assign w_aligned_addr = {r_addr[31:2], 2'b00};

    // Decode the incoming request: legality of op for its direction and alignment
    always_comb begin
        w_is_half    = (req_op == DM_OP_HS) || (req_op == DM_OP_HZ) || (req_op == DM_OP_SH);
        w_is_word    = (req_op == DM_OP_WD);
        if (req_we) begin
            w_op_illegal = !((req_op == DM_OP_SB) || (req_op == DM_OP_SH) || (req_op == DM_OP_WD));
        end else begin
            w_op_illegal = !((req_op == DM_OP_BS) || (req_op == DM_OP_BZ) ||
                             (req_op == DM_OP_HS) || (req_op == DM_OP_HZ) ||
                             (req_op == DM_OP_WD));
        end
`ifdef LSU_ALIGN_CHECK_EN
        w_misalign   = (w_is_half && req_addr[0]) || (w_is_word && (req_addr[1:0] != 2'b00));
`else
        w_misalign   = 1'b0;
`endif
        w_req_err    = w_op_illegal || w_misalign;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: errors skip memory, sub-word stores read before writing
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err)              w_next_state = S_RESP;
                    else if (!req_we)           w_next_state = S_RD;
                    else if (req_op == DM_OP_WD) w_next_state = S_WR;
                    else                        w_next_state = S_RD;
                end
            end
            S_RD:    w_next_state = r_we ? S_WR : S_RESP;
            S_WR:    w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request fields latched on accept; memory word captured at the end of RD
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_op    <= DM_OP_WD;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_op    <= req_op;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_err   <= w_req_err;
            end
            if (r_state == S_RD) begin
                r_rdata <= dm_rdata;
            end
        end
    end

    // Lane selection and extension for loads, lane replacement for sub-word stores
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = r_rdata[31:24];
            2'd1:    w_byte = r_rdata[23:16];
            2'd2:    w_byte = r_rdata[15:8];
            default: w_byte = r_rdata[7:0];
        endcase
        w_half = r_addr[1] ? r_rdata[15:0] : r_rdata[31:16];

        case (r_op)
            DM_OP_BS: w_load = {{24{w_byte[7]}}, w_byte};
            DM_OP_BZ: w_load = {24'd0, w_byte};
            DM_OP_HS: w_load = {{16{w_half[15]}}, w_half};
            DM_OP_HZ: w_load = {16'd0, w_half};
            default:  w_load = r_rdata;
        endcase

        w_merge = r_wdata;
        if (r_op == DM_OP_SB) begin
            case (r_addr[1:0])
                2'd0:    w_merge = {r_wdata[7:0], r_rdata[23:0]};
                2'd1:    w_merge = {r_rdata[31:24], r_wdata[7:0], r_rdata[15:0]};
                2'd2:    w_merge = {r_rdata[31:16], r_wdata[7:0], r_rdata[7:0]};
                default: w_merge = {r_rdata[31:8], r_wdata[7:0]};
            endcase
        end else if (r_op == DM_OP_SH) begin
            w_merge = r_addr[1] ? {r_rdata[31:16], r_wdata[15:0]}
                                : {r_wdata[15:0], r_rdata[15:0]};
        end
    end

    // Outputs per state; memory strobes are gated by reset so a reset in WR drops the write
    always_comb begin
        req_ready   = (r_state == S_IDLE);
        resp_valid  = 1'b0;
        resp_rdata  = 32'd0;
        resp_err    = 1'b0;
        dm_w        = 1'b0;
        dm_r        = 1'b0;
        dm_addr     = 32'd0;
        dm_wdata    = 32'd0;
        dm_op       = DM_OP_WD;
        o_dbg_state = r_state;
        case (r_state)
            S_RD: begin
                dm_r    = !rst;
                dm_addr = w_aligned_addr;
            end
            S_WR: begin
                dm_w     = !rst;
                dm_addr  = w_aligned_addr;
                dm_wdata = w_merge;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_rdata = (!r_we && !r_err) ? w_load : 32'd0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a word-addressed memory model, a driver that issues
// requests and queues the expected response (data, error, due cycle), and a
// monitor that pops and compares on every resp_valid pulse.
module tb_lsu;

  localparam logic [2:0] DM_OP_WD = 3'd0;
  localparam logic [2:0] DM_OP_BS = 3'd1;
  localparam logic [2:0] DM_OP_BZ = 3'd2;
  localparam logic [2:0] DM_OP_HS = 3'd3;
  localparam logic [2:0] DM_OP_HZ = 3'd4;
  localparam logic [2:0] DM_OP_SB = 3'd5;
  localparam logic [2:0] DM_OP_SH = 3'd6;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dm_w;
  logic        dm_r;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  dm_op;
  logic [31:0] dm_rdata;
  logic [1:0]  dbg_state;

  lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_w(dm_w), .dm_r(dm_r), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_op(dm_op), .dm_rdata(dm_rdata), .o_dbg_state(dbg_state)
  );

  // memory model: combinational read, write on rising edge, preload port
  logic [31:0] mem [0:63];
  logic        ld_en = 1'b0;
  logic [5:0]  ld_idx = 6'd0;
  logic [31:0] ld_data = 32'd0;
  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_data;
    else if (dm_w) mem[dm_addr[7:2]] <= dm_wdata;
  end
  assign dm_rdata = mem[dm_addr[7:2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [64:0] exp_q[$];
  logic [64:0] e;
  int dmw_cnt = 0;
  int dmr_cnt = 0;
  logic [31:0] last_waddr = 32'd0;
  logic [31:0] last_wdata = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (dm_w) begin
        dmw_cnt++;
        last_waddr = dm_addr;
        last_wdata = dm_wdata;
      end else begin
        check("dm_wdata_outside_wr", dm_wdata, 32'd0);
      end
      if (dm_r) dmr_cnt++;
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_resp: got resp_valid=1, expected no response (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("resp_rdata", resp_rdata, e[31:0]);
          check("resp_err", {31'd0, resp_err}, {31'd0, e[32]});
          check("resp_cycle", cyc, e[64:33]);
        end
      end else begin
        check("idle_rdata", resp_rdata, 32'd0);
        check("idle_err", {31'd0, resp_err}, 32'd0);
      end
    end
  end

  // driver tasks
  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL resp_timeout: got %0d pending responses, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int lat);
    int t;
    logic [31:0] due;
    req_we = we; req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL req_ready_timeout: got req_ready=0, expected 1");
      req_valid = 1'b0;
      return;
    end
    due = cyc + lat;
    exp_q.push_back({due, exp_err, exp_rdata});
    @(posedge clk);
    #1 req_valid = 1'b0;
    drain();
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    ld_en = 1'b1; ld_idx = idx; ld_data = data;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  int bw, br;
  logic [31:0] due2;

  initial begin
    // reset with memory preload
    rst = 1'b1;
    preload(6'd4, 32'h80FF1234);
    preload(6'd5, 32'h11223344);
    preload(6'd8, 32'h00000000);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_dm_w", {31'd0, dm_w}, 32'd0);
    check("rst_dm_r", {31'd0, dm_r}, 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_wdata", dm_wdata, 32'd0);
    check("rst_dm_op", {29'd0, dm_op}, {29'd0, DM_OP_WD});
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // loads on 0x80FF1234 at 0x10
    issue(1'b0, DM_OP_BS, 32'h11, 32'd0, 32'hFFFFFFFF, 1'b0, 2);
    issue(1'b0, DM_OP_BZ, 32'h10, 32'd0, 32'h00000080, 1'b0, 2);
    issue(1'b0, DM_OP_HS, 32'h12, 32'd0, 32'h00001234, 1'b0, 2);
    issue(1'b0, DM_OP_HZ, 32'h10, 32'd0, 32'h000080FF, 1'b0, 2);
    issue(1'b0, DM_OP_HS, 32'h10, 32'd0, 32'hFFFF80FF, 1'b0, 2);
    issue(1'b0, DM_OP_BZ, 32'h13, 32'd0, 32'h00000034, 1'b0, 2);
    issue(1'b0, DM_OP_WD, 32'h10, 32'd0, 32'h80FF1234, 1'b0, 2);
`ifdef LSU_ALIGN_CHECK_EN
    issue(1'b0, DM_OP_HS, 32'h11, 32'd0, 32'h00000000, 1'b1, 1);
`else
    issue(1'b0, DM_OP_HS, 32'h11, 32'd0, 32'hFFFF80FF, 1'b0, 2);
`endif

    // byte store: read-modify-write, one write cycle
    bw = dmw_cnt;
    issue(1'b1, DM_OP_SB, 32'h13, 32'h000000AB, 32'd0, 1'b0, 3);
    check("sb_dm_w_count", dmw_cnt - bw, 32'd1);
    check("sb_dm_wdata", last_wdata, 32'h80FF12AB);
    check("sb_dm_addr", last_waddr, 32'h10);
    issue(1'b0, DM_OP_WD, 32'h10, 32'd0, 32'h80FF12AB, 1'b0, 2);

    // misaligned word store
    bw = dmw_cnt;
`ifdef LSU_ALIGN_CHECK_EN
    issue(1'b1, DM_OP_WD, 32'h22, 32'hCAFEF00D, 32'd0, 1'b1, 1);
    check("wd22_dm_w_count", dmw_cnt - bw, 32'd0);
    check("wd22_mem", mem[8], 32'h00000000);
`else
    issue(1'b1, DM_OP_WD, 32'h22, 32'hCAFEF00D, 32'd0, 1'b0, 2);
    check("wd22_dm_w_count", dmw_cnt - bw, 32'd1);
    check("wd22_dm_addr", last_waddr, 32'h20);
    check("wd22_mem", mem[8], 32'hCAFEF00D);
`endif

    // illegal ops: no memory access
    bw = dmw_cnt; br = dmr_cnt;
    issue(1'b1, DM_OP_BZ, 32'h14, 32'h12345678, 32'd0, 1'b1, 1);
    issue(1'b0, DM_OP_SB, 32'h14, 32'd0, 32'd0, 1'b1, 1);
    check("illegal_dm_w_count", dmw_cnt - bw, 32'd0);
    check("illegal_dm_r_count", dmr_cnt - br, 32'd0);
    check("illegal_mem", mem[5], 32'h11223344);

    // reset during the WR cycle of a halfword store
    bw = dmw_cnt; br = dmr_cnt;
    req_we = 1'b1; req_op = DM_OP_SH; req_addr = 32'h16; req_wdata = 32'h00005566;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rstwr_state", {30'd0, dbg_state}, 32'd2);
    check("rstwr_dm_w", {31'd0, dm_w}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstwr_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("rstwr_dm_w_count", dmw_cnt - bw, 32'd0);
    check("rstwr_dm_r_count", dmr_cnt - br, 32'd1);
    check("rstwr_mem", mem[5], 32'h11223344);

    // same halfword store without reset
    issue(1'b1, DM_OP_SH, 32'h16, 32'h00005566, 32'd0, 1'b0, 3);
    check("sh_mem", mem[5], 32'h11225566);

    // back-to-back loads with req_valid held high
    req_we = 1'b0; req_op = DM_OP_BZ; req_addr = 32'h13; req_wdata = 32'd0;
    req_valid = 1'b1;
    check("b2b_ready_first", {31'd0, req_ready}, 32'd1);
    due2 = cyc + 2;
    exp_q.push_back({due2, 1'b0, 32'h000000AB});
    @(posedge clk);
    #1 req_op = DM_OP_HZ; req_addr = 32'h14;
    @(negedge clk);
    check("b2b_ready_rd", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("b2b_ready_resp", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("b2b_ready_after", {31'd0, req_ready}, 32'd1);
    due2 = cyc + 2;
    exp_q.push_back({due2, 1'b0, 32'h00001122});
    @(posedge clk);
    #1 req_valid = 1'b0;
    drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
